// File: rtl/core_pkg.sv
// Shared core types: renamed micro-op layout and dispatch-stage sizing constants.
package core_pkg;
    localparam int DISPATCH_W = 2;
    localparam int DQ_DEPTH   = 8;
    localparam int NUM_PREGS  = 64;
    localparam int PHYS_W     = $clog2(NUM_PREGS);
    localparam int CORE_XLEN  = 32;
    localparam int AREG_W     = 5;

    typedef struct packed {
        logic [6:0]           opcode;
        logic [2:0]           func;
        logic [PHYS_W-1:0]    prs1;
        logic [PHYS_W-1:0]    prs2;
        logic [PHYS_W-1:0]    prd;
        logic                 rs1_valid;
        logic                 rs2_valid;
        logic                 rd_valid;
        logic [CORE_XLEN-1:0] imm;
        logic [CORE_XLEN-1:0] pc;
        logic [AREG_W-1:0]    rs1;
        logic [AREG_W-1:0]    rs2;
        logic [AREG_W-1:0]    rd;
        logic                 is_alu;
        logic                 is_load;
        logic                 is_store;
        logic                 is_branch;
        logic                 is_cas;
    } uop_t;

    function automatic logic uop_is_mem(input uop_t u);
        return u.is_load | u.is_store | u.is_cas;
    endfunction

    function automatic logic uop_is_rs(input uop_t u);
        return u.is_alu | u.is_branch;
    endfunction
endpackage

// File: rtl/preg_scoreboard.sv
// Physical-register readiness bits: clears from producers, sets from CDB, bulk set on flush.
module preg_scoreboard #(
    parameter  int PREGS = 64,
    parameter  int NCLR  = 2,
    parameter  int NSET  = 2,
    localparam int TW    = $clog2(PREGS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NCLR-1:0]           clr_en_i,
    input  logic [NCLR-1:0][TW-1:0]   clr_tag_i,
    input  logic [NSET-1:0]           set_en_i,
    input  logic [NSET-1:0][TW-1:0]   set_tag_i,
    input  logic                      flush_i,
    input  logic [PREGS-1:0]          flush_mask_i,
    output logic [PREGS-1:0]          ready_o
);
    logic [PREGS-1:0] rdy_q, rdy_d;

    // Later updates override earlier ones: clear, then CDB set, then flush mask.
    always_comb begin
        rdy_d = rdy_q;
        for (int i = 0; i < NCLR; i++)
            if (clr_en_i[i]) rdy_d[clr_tag_i[i]] = 1'b0;
        for (int i = 0; i < NSET; i++)
            if (set_en_i[i]) rdy_d[set_tag_i[i]] = 1'b1;
        if (flush_i) rdy_d = rdy_d | flush_mask_i;
        rdy_d[0] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdy_q <= '1;
        else          rdy_q <= rdy_d;
    end

    assign ready_o = rdy_q;
endmodule

// File: rtl/dispatch_queue.sv
// In-order circular dispatch buffer between rename and RS/ROB/LSU; drains the longest
// credit-legal prefix of the head each cycle and reports operand readiness.
module dispatch_queue
    import core_pkg::*;
#(
    parameter  int W         = DISPATCH_W,
    parameter  int DEPTH     = DQ_DEPTH,
    parameter  int MEM_PORTS = 1,
    parameter  int CDB_W     = 2,
    parameter  int PREGS     = NUM_PREGS,
    parameter  int XLEN      = CORE_XLEN,
    parameter  int ROB_IDX_W = 5,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = PTR_W + 1,
    localparam int PW        = $clog2(PREGS)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [W-1:0]                  enq_valid,
    output logic                          enq_ready,
    input  uop_t [W-1:0]                  enq_uop,
    input  logic                          flush,
    input  logic [PREGS-1:0]              flush_ready_mask,
    input  logic [CNT_W-1:0]              rob_credits,
    input  logic [CNT_W-1:0]              rs_credits,
    input  logic [CNT_W-1:0]              lsu_credits,
    input  logic [ROB_IDX_W-1:0]          rob_base_idx,
    output logic [W-1:0]                  disp_en,
    output uop_t [W-1:0]                  disp_uop,
    output logic [W-1:0][ROB_IDX_W-1:0]   disp_rob_idx,
    output logic [W-1:0]                  disp_to_rs,
    output logic [W-1:0]                  disp_to_lsu,
    output logic [W-1:0]                  disp_src1_ready,
    output logic [W-1:0]                  disp_src2_ready,
    input  logic [CDB_W-1:0]              cdb_valid,
    input  logic [CDB_W-1:0][PW-1:0]      cdb_tag,
    output logic [CNT_W-1:0]              occupancy
);
    if (XLEN != CORE_XLEN || PW != PHYS_W || W < 1 || W > 4 || DEPTH < 2 * W ||
        MEM_PORTS < 1 || MEM_PORTS > W) begin : g_bad_cfg
        $error("dispatch_queue: unsupported parameter set");
    end

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    uop_t                buf_q [DEPTH];
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    occ_q, occ_d;
    uop_t [W-1:0]        head_uop;
    logic [W-1:0]        lane_vld, is_rs, is_mem, rdy1, rdy2, sb_clr;
    logic [W-1:0][PW-1:0] sb_clr_tag;
    logic [CNT_W-1:0]    enq_cnt, deq_cnt, rob_c, rs_c, mem_c, mem_lim;
    logic                stop;
    logic [PREGS-1:0]    sb_rdy;

    assign enq_ready = !flush && ((CNT_W'(DEPTH) - occ_q) >= CNT_W'(W));
    assign occupancy = occ_q;

    always_comb begin
        for (int i = 0; i < W; i++) begin
            head_uop[i]   = buf_q[head_q + PTR_W'(i)];
            lane_vld[i]   = CNT_W'(i) < occ_q;
            is_rs[i]      = uop_is_rs(head_uop[i]);
            is_mem[i]     = uop_is_mem(head_uop[i]);
        end
    end

    // A lane that misses any credit stops the group; younger lanes never skip ahead.
    always_comb begin
        disp_en = '0;
        rob_c   = '0;
        rs_c    = '0;
        mem_c   = '0;
        stop    = 1'b0;
        mem_lim = (CNT_W'(MEM_PORTS) < lsu_credits) ? CNT_W'(MEM_PORTS) : lsu_credits;
        for (int i = 0; i < W; i++) begin
            if (!stop && !flush && lane_vld[i]
                && (rob_c + ONE <= rob_credits)
                && (rs_c + CNT_W'(is_rs[i]) <= rs_credits)
                && (mem_c + CNT_W'(is_mem[i]) <= mem_lim)) begin
                disp_en[i] = 1'b1;
                rob_c      = rob_c + ONE;
                rs_c       = rs_c + CNT_W'(is_rs[i]);
                mem_c      = mem_c + CNT_W'(is_mem[i]);
            end else begin
                stop = 1'b1;
            end
        end
    end

    always_comb begin
        rdy1 = '0;
        rdy2 = '0;
        for (int i = 0; i < W; i++) begin
            rdy1[i] = sb_rdy[head_uop[i].prs1];
            rdy2[i] = sb_rdy[head_uop[i].prs2];
            for (int c = 0; c < CDB_W; c++) begin
                if (cdb_valid[c] && cdb_tag[c] == head_uop[i].prs1) rdy1[i] = 1'b1;
                if (cdb_valid[c] && cdb_tag[c] == head_uop[i].prs2) rdy2[i] = 1'b1;
            end
            // An older lane of the same group produces this operand; scoreboard hasn't seen it yet.
            for (int j = 0; j < i; j++) begin
                if (head_uop[j].rd_valid && head_uop[j].prd == head_uop[i].prs1) rdy1[i] = 1'b0;
                if (head_uop[j].rd_valid && head_uop[j].prd == head_uop[i].prs2) rdy2[i] = 1'b0;
            end
            if (!head_uop[i].rs1_valid || head_uop[i].prs1 == '0) rdy1[i] = 1'b1;
            if (!head_uop[i].rs2_valid || head_uop[i].prs2 == '0) rdy2[i] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < W; i++) begin
            disp_uop[i]     = lane_vld[i] ? head_uop[i] : '0;
            disp_rob_idx[i] = lane_vld[i] ? rob_base_idx + ROB_IDX_W'(i) : '0;
            sb_clr[i]       = disp_en[i] && head_uop[i].rd_valid && head_uop[i].prd != '0;
            sb_clr_tag[i]   = head_uop[i].prd;
        end
        disp_to_rs      = disp_en & is_rs;
        disp_to_lsu     = disp_en & is_mem;
        disp_src1_ready = lane_vld & rdy1;
        disp_src2_ready = lane_vld & rdy2;
    end

    always_comb begin
        enq_cnt = enq_ready ? CNT_W'($countones(enq_valid)) : '0;
        deq_cnt = CNT_W'($countones(disp_en));
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            head_d = head_q + PTR_W'(deq_cnt);
            tail_d = tail_q + PTR_W'(enq_cnt);
            occ_d  = occ_q + enq_cnt - deq_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < W; i++)
            if (enq_ready && enq_valid[i]) buf_q[tail_q + PTR_W'(i)] <= enq_uop[i];
    end

    preg_scoreboard #(.PREGS(PREGS), .NCLR(W), .NSET(CDB_W)) u_sb (
        .clk          (clk),
        .reset_n      (reset_n),
        .clr_en_i     (sb_clr),
        .clr_tag_i    (sb_clr_tag),
        .set_en_i     (cdb_valid),
        .set_tag_i    (cdb_tag),
        .flush_i      (flush),
        .flush_mask_i (flush_ready_mask),
        .ready_o      (sb_rdy)
    );

    a_enq_contig: assert property (@(posedge clk) disable iff (!reset_n)
        ((enq_valid & (enq_valid + W'(1))) == '0));
    a_occ_bound: assert property (@(posedge clk) disable iff (!reset_n)
        (occ_q <= CNT_W'(DEPTH)));
endmodule

// File: tb/tb_dispatch_queue.sv
// Scoreboard bench for dispatch_queue: enqueued uops are queued and matched in order at dispatch.
module tb_dispatch_queue;
    import core_pkg::*;
    localparam int W = 2, DEPTH = 8, CDB_W = 2, PREGS = 64, ROB_IDX_W = 5, CNT_W = 4;
    localparam int C_ALU = 0, C_LD = 1, C_ST = 2, C_BR = 3;

    logic clk = 1'b0, reset_n = 1'b1;
    logic [W-1:0] enq_valid = '0;
    logic enq_ready;
    uop_t [W-1:0] enq_uop = '0;
    logic flush = 1'b0;
    logic [PREGS-1:0] flush_ready_mask = '0;
    logic [CNT_W-1:0] rob_credits = 4'd8, rs_credits = 4'd8, lsu_credits = 4'd8;
    logic [ROB_IDX_W-1:0] rob_base_idx = '0;
    logic [W-1:0] disp_en, disp_to_rs, disp_to_lsu, disp_src1_ready, disp_src2_ready;
    uop_t [W-1:0] disp_uop;
    logic [W-1:0][ROB_IDX_W-1:0] disp_rob_idx;
    logic [CDB_W-1:0] cdb_valid = '0;
    logic [CDB_W-1:0][PHYS_W-1:0] cdb_tag = '0;
    logic [CNT_W-1:0] occupancy;

    int checks = 0, fails = 0;
    uop_t exp_q[$];

    always #5 clk = ~clk;

    dispatch_queue dut (
        .clk(clk), .reset_n(reset_n), .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_uop(enq_uop), .flush(flush), .flush_ready_mask(flush_ready_mask),
        .rob_credits(rob_credits), .rs_credits(rs_credits), .lsu_credits(lsu_credits),
        .rob_base_idx(rob_base_idx), .disp_en(disp_en), .disp_uop(disp_uop),
        .disp_rob_idx(disp_rob_idx), .disp_to_rs(disp_to_rs), .disp_to_lsu(disp_to_lsu),
        .disp_src1_ready(disp_src1_ready), .disp_src2_ready(disp_src2_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .occupancy(occupancy)
    );

    // In-order scoreboard: every dispatched lane must be the oldest outstanding uop.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < W; i++) begin
                if (disp_en[i]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL sb_order lane%0d: got pc %h, expected nothing", i, disp_uop[i].pc);
                    end else begin
                        uop_t e;
                        e = exp_q.pop_front();
                        if (disp_uop[i] !== e) begin
                            fails++;
                            $display("FAIL sb_order lane%0d: got pc %h, expected pc %h", i, disp_uop[i].pc, e.pc);
                        end
                    end
                end
            end
        end
    end

    function automatic uop_t mk(input int cls, input logic [31:0] pc, input int prd,
                                input int prs1, input int prs2, input logic rdv,
                                input logic s1v, input logic s2v);
        uop_t u;
        u = '0;
        u.opcode    = pc[8:2];
        u.imm       = ~pc;
        u.pc        = pc;
        u.prd       = PHYS_W'(prd);
        u.prs1      = PHYS_W'(prs1);
        u.prs2      = PHYS_W'(prs2);
        u.rd_valid  = rdv;
        u.rs1_valid = s1v;
        u.rs2_valid = s2v;
        u.is_alu    = (cls == C_ALU);
        u.is_load   = (cls == C_LD);
        u.is_store  = (cls == C_ST);
        u.is_branch = (cls == C_BR);
        return u;
    endfunction

    function automatic uop_t alu(input logic [31:0] pc);
        return mk(C_ALU, pc, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq2(input uop_t a, input uop_t b, input int n);
        enq_uop[0] = a;
        enq_uop[1] = b;
        enq_valid  = (n == 2) ? 2'b11 : 2'b01;
        exp_q.push_back(a);
        if (n == 2) exp_q.push_back(b);
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #2;
        checks++; if (occupancy !== 4'd0) begin fails++; $display("FAIL rst_occ: got %0d expected 0", occupancy); end
        checks++; if (disp_en !== 2'b00) begin fails++; $display("FAIL rst_disp_en: got %b expected 00", disp_en); end
        checks++; if (enq_ready !== 1'b1) begin fails++; $display("FAIL rst_enq_ready: got %b expected 1", enq_ready); end
        checks++; if (disp_src1_ready !== 2'b00) begin fails++; $display("FAIL rst_src1: got %b expected 00", disp_src1_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_pair();
        rob_base_idx = 5'd31;
        enq2(alu(32'h100), mk(C_BR, 32'h104, 0, 0, 0, 1'b0, 1'b0, 1'b0), 2);
        @(negedge clk);
        checks++; if (disp_en !== 2'b00) begin fails++; $display("FAIL no_bypass: got %b expected 00", disp_en); end
        tick(); enq_valid = '0;
        @(negedge clk);
        checks++; if (disp_en !== 2'b11) begin fails++; $display("FAIL pair_en: got %b expected 11", disp_en); end
        checks++; if (occupancy !== 4'd2) begin fails++; $display("FAIL pair_occ: got %0d expected 2", occupancy); end
        checks++; if (disp_rob_idx[0] !== 5'd31 || disp_rob_idx[1] !== 5'd0) begin
            fails++; $display("FAIL pair_rob_idx: got %0d,%0d expected 31,0", disp_rob_idx[0], disp_rob_idx[1]); end
        checks++; if (disp_to_rs !== 2'b11 || disp_to_lsu !== 2'b00) begin
            fails++; $display("FAIL pair_route: got rs=%b lsu=%b expected rs=11 lsu=00", disp_to_rs, disp_to_lsu); end
        tick();
        @(negedge clk);
        checks++; if (occupancy !== 4'd0) begin fails++; $display("FAIL pair_drain: got %0d expected 0", occupancy); end
        tick();
    endtask

    task automatic test_mem_port();
        rob_base_idx = 5'd3;
        lsu_credits  = 4'd0;
        enq2(mk(C_LD, 32'h200, 5, 0, 0, 1'b1, 1'b0, 1'b0), mk(C_ST, 32'h204, 0, 0, 0, 1'b0, 1'b0, 1'b0), 2);
        tick(); enq_valid = '0;
        @(negedge clk);
        checks++; if (disp_en !== 2'b00) begin fails++; $display("FAIL lsu_credit0: got %b expected 00", disp_en); end
        tick(); lsu_credits = 4'd8;
        @(negedge clk);
        checks++; if (disp_en !== 2'b01) begin fails++; $display("FAIL mem_port_en: got %b expected 01", disp_en); end
        checks++; if (disp_to_lsu !== 2'b01) begin fails++; $display("FAIL mem_port_lsu: got %b expected 01", disp_to_lsu); end
        checks++; if (disp_rob_idx[0] !== 5'd3) begin fails++; $display("FAIL mem_rob0: got %0d expected 3", disp_rob_idx[0]); end
        tick(); rob_base_idx = 5'd4;
        @(negedge clk);
        checks++; if (disp_en !== 2'b01 || disp_uop[0].pc !== 32'h204) begin
            fails++; $display("FAIL store_next: got en=%b pc=%h expected en=01 pc=204", disp_en, disp_uop[0].pc); end
        checks++; if (disp_rob_idx[0] !== 5'd4 || occupancy !== 4'd1) begin
            fails++; $display("FAIL store_idx_occ: got idx=%0d occ=%0d expected 4,1", disp_rob_idx[0], occupancy); end
        tick();
    endtask

    task automatic test_raw();
        rob_base_idx = 5'd0;
        enq2(mk(C_ALU, 32'h300, 7, 0, 0, 1'b1, 1'b0, 1'b0), mk(C_ALU, 32'h304, 0, 7, 0, 1'b0, 1'b1, 1'b1), 2);
        tick(); enq_valid = '0;
        @(negedge clk);
        checks++; if (disp_en !== 2'b11) begin fails++; $display("FAIL raw_en: got %b expected 11", disp_en); end
        checks++; if (disp_src1_ready !== 2'b01) begin fails++; $display("FAIL raw_intra: got %b expected 01", disp_src1_ready); end
        checks++; if (disp_src2_ready !== 2'b11) begin fails++; $display("FAIL raw_p0_ready: got %b expected 11", disp_src2_ready); end
        tick();
        rob_credits = 4'd0;
        enq2(mk(C_ALU, 32'h310, 0, 7, 0, 1'b0, 1'b1, 1'b0), mk(C_ALU, 32'h314, 0, 7, 9, 1'b0, 1'b1, 1'b1), 2);
        tick(); enq_valid = '0;
        @(negedge clk);
        checks++; if (disp_src1_ready !== 2'b00) begin fails++; $display("FAIL sb_cleared: got %b expected 00", disp_src1_ready); end
        tick();
        cdb_tag[0] = 6'd7; cdb_tag[1] = 6'd7; cdb_valid = 2'b10;
        @(negedge clk);
        checks++; if (disp_src1_ready !== 2'b11) begin fails++; $display("FAIL cdb_bypass: got %b expected 11", disp_src1_ready); end
        tick(); cdb_valid = '0;
        @(negedge clk);
        checks++; if (disp_src1_ready !== 2'b11) begin fails++; $display("FAIL cdb_set: got %b expected 11", disp_src1_ready); end
        tick(); rob_credits = 4'd8;
        @(negedge clk);
        checks++; if (disp_en !== 2'b11) begin fails++; $display("FAIL raw_release: got %b expected 11", disp_en); end
        tick();
    endtask

    task automatic test_fill_wrap();
        bit done;
        enq2(alu(32'h400), '0, 1);
        tick(); enq_valid = '0;
        tick();
        rob_credits = 4'd0;
        for (int p = 0; p < 4; p++) begin
            enq2(alu(32'h410 + 32'(8 * p)), alu(32'h414 + 32'(8 * p)), 2);
            @(negedge clk);
            checks++; if (occupancy !== CNT_W'(2 * p) || enq_ready !== 1'b1) begin
                fails++; $display("FAIL fill_step%0d: got occ=%0d rdy=%b expected occ=%0d rdy=1", p, occupancy, enq_ready, 2 * p); end
            tick();
        end
        enq_valid = '0;
        @(negedge clk);
        checks++; if (occupancy !== 4'd8 || enq_ready !== 1'b0 || disp_en !== 2'b00) begin
            fails++; $display("FAIL full: got occ=%0d rdy=%b en=%b expected 8,0,00", occupancy, enq_ready, disp_en); end
        tick(); rob_credits = 4'd2;
        @(negedge clk);
        checks++; if (disp_en !== 2'b11) begin fails++; $display("FAIL rob_credit2: got %b expected 11", disp_en); end
        tick();
        enq2(alu(32'h440), alu(32'h444), 2);
        @(negedge clk);
        checks++; if (occupancy !== 4'd6 || enq_ready !== 1'b1 || disp_en !== 2'b11) begin
            fails++; $display("FAIL enq_deq: got occ=%0d rdy=%b en=%b expected 6,1,11", occupancy, enq_ready, disp_en); end
        tick(); enq_valid = '0; rob_credits = 4'd8; rs_credits = 4'd1;
        @(negedge clk);
        checks++; if (disp_en !== 2'b01 || occupancy !== 4'd6) begin
            fails++; $display("FAIL rs_credit1: got en=%b occ=%0d expected 01,6", disp_en, occupancy); end
        tick(); rs_credits = 4'd8;
        done = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk);
            if (occupancy == 4'd0) done = 1'b1;
            else tick();
        end
        checks++; if (!done) begin fails++; $display("FAIL wrap_drain: got occ=%0d expected 0 within 10 cycles", occupancy); end
        tick();
    endtask

    task automatic test_flush();
        enq2(mk(C_ALU, 32'h500, 12, 0, 0, 1'b1, 1'b0, 1'b0), '0, 1);
        tick(); enq_valid = '0;
        tick();
        rob_credits = 4'd0;
        enq2(mk(C_ALU, 32'h510, 0, 12, 0, 1'b0, 1'b1, 1'b0), alu(32'h514), 2); tick();
        enq2(alu(32'h518), alu(32'h51c), 2); tick();
        enq2(alu(32'h520), '0, 1); tick(); enq_valid = '0;
        @(negedge clk);
        checks++; if (occupancy !== 4'd5 || disp_src1_ready[0] !== 1'b0) begin
            fails++; $display("FAIL pre_flush: got occ=%0d src1=%b expected 5,0", occupancy, disp_src1_ready[0]); end
        tick();
        flush = 1'b1; flush_ready_mask = '0; flush_ready_mask[12] = 1'b1; rob_credits = 4'd8;
        enq2(alu(32'h530), alu(32'h534), 2);
        @(negedge clk);
        checks++; if (disp_en !== 2'b00) begin fails++; $display("FAIL flush_disp: got %b expected 00", disp_en); end
        checks++; if (enq_ready !== 1'b0) begin fails++; $display("FAIL flush_enq_ready: got %b expected 0", enq_ready); end
        tick(); flush = 1'b0; flush_ready_mask = '0; enq_valid = '0;
        exp_q.delete();
        @(negedge clk);
        checks++; if (occupancy !== 4'd0) begin fails++; $display("FAIL flush_occ: got %0d expected 0", occupancy); end
        tick();
        enq2(mk(C_ALU, 32'h540, 0, 12, 0, 1'b0, 1'b1, 1'b0), '0, 1);
        tick(); enq_valid = '0;
        @(negedge clk);
        checks++; if (disp_src1_ready[0] !== 1'b1 || disp_en !== 2'b01) begin
            fails++; $display("FAIL flush_mask_set: got src1=%b en=%b expected 1,01", disp_src1_ready[0], disp_en); end
        tick();
    endtask

    task automatic test_reset_mid();
        enq2(mk(C_ALU, 32'h600, 20, 0, 0, 1'b1, 1'b0, 1'b0), '0, 1);
        tick(); enq_valid = '0;
        tick();
        rob_credits = 4'd0; rob_base_idx = 5'd7;
        enq2(mk(C_ALU, 32'h610, 0, 20, 0, 1'b0, 1'b1, 1'b0), alu(32'h614), 2);
        tick(); enq_valid = '0;
        @(negedge clk);
        checks++; if (occupancy !== 4'd2 || disp_src1_ready !== 2'b10) begin
            fails++; $display("FAIL pre_reset: got occ=%0d src1=%b expected 2,10", occupancy, disp_src1_ready); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (occupancy !== 4'd0 || disp_en !== 2'b00 || disp_rob_idx !== '0 || disp_src1_ready !== 2'b00) begin
            fails++; $display("FAIL async_reset: got occ=%0d en=%b idx0=%0d src1=%b expected 0,00,0,00",
                              occupancy, disp_en, disp_rob_idx[0], disp_src1_ready); end
        exp_q.delete();
        rob_credits = 4'd8;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        checks++; if (enq_ready !== 1'b1) begin fails++; $display("FAIL post_reset_rdy: got %b expected 1", enq_ready); end
        enq2(mk(C_ALU, 32'h620, 0, 20, 0, 1'b0, 1'b1, 1'b0), '0, 1);
        tick(); enq_valid = '0;
        @(negedge clk);
        checks++; if (disp_src1_ready[0] !== 1'b1 || disp_en !== 2'b01) begin
            fails++; $display("FAIL post_reset_sb: got src1=%b en=%b expected 1,01", disp_src1_ready[0], disp_en); end
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_pair();
        test_mem_port();
        test_raw();
        test_fill_wrap();
        test_flush();
        test_reset_mid();
        tick();
        checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL sb_leftover: got %0d pending expected 0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
Parametrised successor to the 2-wide combinational dispatch stage. It places a DEPTH-entry in-order circular dispatch buffer between rename and RS/ROB/LSU. Each cycle it drains the oldest in-order prefix the downstream credits allow, supporting up to MEM_PORTS memory ops. It owns the preg readiness scoreboard, including intra-group dependency detection and flush recovery.

Parameters:
W, 2, dispatch/enqueue width (1..4)
DEPTH, 8, buffer entries (power of 2, >= 2*W)
MEM_PORTS, 1, max load/store/CAS dispatched per cycle (1..W)
CDB_W, 2, CDB broadcast ports
PREGS, 64, physical registers; PHYS_W = $clog2(PREGS)
XLEN, 32, datapath width
ROB_IDX_W, 5, ROB index width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
enq_valid  in  W  per-lane rename valid; lanes contiguous from lane 0
enq_ready  out  1  buffer free count >= W; enqueue only when high
enq_uop  in  W x uop_t  renamed micro-op (opcode, func, prs1/prs2/prd, rs1/rs2/rd valid, imm, pc, arch regs, class)
flush  in  1  pipeline squash
flush_ready_mask  in  PREGS  pregs squashed this flush; forced ready
rob_credits  in  $clog2(DEPTH)+1  free ROB slots
rs_credits  in  $clog2(DEPTH)+1  free RS slots
lsu_credits  in  $clog2(DEPTH)+1  free LSQ slots
rob_base_idx  in  ROB_IDX_W  ROB index assigned to disp lane 0
disp_en  out  W  lanes dispatched this cycle (prefix mask)
disp_uop  out  W x uop_t  head uops
disp_rob_idx  out  W x ROB_IDX_W  rob_base_idx + lane, mod 2^ROB_IDX_W
disp_to_rs  out  W  lane goes to RS (ALU/branch)
disp_to_lsu  out  W  lane goes to LSU
disp_src1_ready  out  W  operand ready at dispatch
disp_src2_ready  out  W  operand ready at dispatch
cdb_valid  in  CDB_W  broadcast valid
cdb_tag  in  CDB_W x PHYS_W  broadcast preg
occupancy  out  $clog2(DEPTH)+1  valid entries

Behaviour:
- Reset (reset_n low, async): head=tail=0; occupancy=0; all scoreboard bits ready; disp_en=0; enq_ready=1; all other outputs 0.
- Enqueue: on the clk edge with enq_ready && enq_valid[i], lane i writes at tail+i. Tail advances by popcount(enq_valid). enq_valid holes are illegal (assertion).
- Entry written at edge t is dispatchable from cycle t+1. No enqueue-to-dispatch bypass.
- Dispatch is combinational from head lanes 0..W-1 (valid = lane < occupancy). k = longest prefix satisfying all of:
  - rob count <= rob_credits
  - RS-class count <= rs_credits
  - mem count <= min(MEM_PORTS, lsu_credits)
- disp_en = (1<<k)-1. Head advances by k at the edge. Stalled lanes keep their order; there is no out-of-order skip.
- Simultaneous enqueue and dequeue are allowed. enq_ready is based on current occupancy (conservative).
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked separately to distinguish full from empty.
- src ready:
  - 1 if the source is not valid or prs==0.
  - else 0 if an older lane j<i in the same dispatch group has rd_valid and prd==prs (intra-group RAW).
  - else scoreboard[prs] OR any cdb_valid with a matching tag (same-cycle bypass).
- Scoreboard update per edge, applied in this order (last wins):
  - dispatched lanes with rd_valid and prd!=0 clear their bit;
  - CDB tags set their bit;
  - on flush, bits in flush_ready_mask are set.
  - preg 0 is always ready.
- Flush: takes priority. Same cycle: disp_en forced 0, enq_ready forced 0. Next edge: head=tail=0, occupancy=0, enqueues that cycle dropped. Scoreboard is updated as above.
- Reset mid-operation discards all entries immediately.

Decomposition:
- core_pkg gains uop_t (packed struct of the renamed fields plus is_alu/is_load/is_store/is_branch/is_cas).
- core_pkg gains DQ_DEPTH and DISPATCH_W constants.
- One sub-module, preg_scoreboard (PREGS bits; clear ports W, set ports CDB_W, mask set on flush), because rename will reuse it.
- The buffer and prefix selection stay in dispatch_queue.

Test Plan:
1. Enqueue 2 ALU uops, all credits 8 -> disp_en=2'b11 the next cycle, occupancy back to 0, rob idx = base, base+1.
2. Lane0 load, lane1 store, MEM_PORTS=1 -> disp_en=2'b01. Store dispatches next cycle as lane 0 with rob idx = new base.
3. Lane0 prd=7, lane1 prs1=7, scoreboard[7]=1 -> lane1 src1_ready=0. Scoreboard[7]=0 after the edge. cdb tag 7 the next cycle -> bit 7 set.
4. Fill to DEPTH=8 with rob_credits=0 -> enq_ready=0, occupancy=8. Raise rob_credits=2 -> two drain, then tail/head wrap past index 7 correctly.
5. Flush with 5 entries, flush_ready_mask bit 12 (previously cleared) -> disp_en=0 that cycle, occupancy=0 next, scoreboard[12]=1.
6. Deassert reset_n mid-stream -> outputs zero asynchronously, all pregs ready, enq_ready=1 after release.
